// File: rtl/neuron_update_scheduler_pkg.sv
// Shared types and constants for the neuron update scheduler.
// Holds the FSM state encoding and the IEEE-754 constants used around the potential adder.
package neuron_sched_pkg;

   typedef enum logic [2:0] {
      StCfg,
      StIdle,
      StExec,
      StWb,
      StSpike,
      StClr
   } sched_state_e;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   // Default LIF threshold (67.89) loaded into the adder; kept here as a reference value.
   localparam logic [31:0] DEFAULT_THRESHOLD = 32'h4287_C7AE;

endpackage

// File: rtl/neuron_pot_regfile.sv
// Membrane potential storage: one combinational read port, one synchronous write port.
// Synchronous reset returns every potential to +0.0.
module neuron_pot_regfile
   import neuron_sched_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = 16,
   parameter int unsigned IDX_W       = 4,
   parameter int unsigned DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem_q [NUM_NEURONS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_NEURONS; k++) begin
            mem_q[k] <= DATA_W'(FP_ZERO);
         end
      end else if (wr_en) begin
         for (int k = 0; k < NUM_NEURONS; k++) begin
            if (wr_idx == IDX_W'(k)) begin
               mem_q[k] <= wr_data;
            end
         end
      end
   end

   // Decoded read keeps indices beyond NUM_NEURONS from touching storage.
   always_comb begin
      rd_data = DATA_W'(FP_ZERO);
      for (int k = 0; k < NUM_NEURONS; k++) begin
         if (rd_idx == IDX_W'(k)) begin
            rd_data = mem_q[k];
         end
      end
   end

endmodule

// File: rtl/neuron_update_scheduler.sv
// Serialises weight events onto one shared LIF potential adder, writes results back
// into the potential array and forwards spikes over a valid/ready handshake.
module neuron_update_scheduler
   import neuron_sched_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = 16,
   parameter int unsigned IDX_W       = 4,
   parameter int unsigned ADDER_LAT   = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_all,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] in_idx,
   input  logic [31:0]      in_weight,
   output logic [31:0]      adder_weight,
   output logic [31:0]      adder_potential,
   output logic             adder_set,
   output logic             adder_clear,
   input  logic [31:0]      adder_result,
   input  logic             adder_spike,
   output logic             spk_valid,
   input  logic             spk_ready,
   output logic [IDX_W-1:0] spk_idx,
   output logic             busy,
   output logic             err_idx,
   output logic [CNT_W-1:0] spike_count
);

   localparam int unsigned    LAT_W    = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ADDER_LAT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);
   localparam logic [IDX_W:0]   IDX_LIM  = (IDX_W + 1)'(NUM_NEURONS);

   sched_state_e     state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      weight_q, weight_d;
   logic [31:0]      res_q, res_d;
   logic             spk_q, spk_d;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
   logic             clear_pending_q, clear_pending_d;
   logic             err_idx_q, err_idx_d;
   logic [CNT_W-1:0] spike_count_q, spike_count_d;

   logic             wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [31:0]      wr_data;
   logic [31:0]      rd_data;
   logic             idx_ok;

   neuron_pot_regfile #(
      .NUM_NEURONS (NUM_NEURONS),
      .IDX_W       (IDX_W),
      .DATA_W      (32)
   ) u_pot_regfile (
      .clk     (clk),
      .rst     (rst),
      .rd_idx  (idx_q),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_data (wr_data)
   );

   assign idx_ok = ({1'b0, in_idx} < IDX_LIM);

   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      weight_d        = weight_q;
      res_d           = res_q;
      spk_d           = spk_q;
      lat_cnt_d       = lat_cnt_q;
      clr_cnt_d       = clr_cnt_q;
      clear_pending_d = clear_pending_q;
      err_idx_d       = err_idx_q;
      spike_count_d   = spike_count_q;
      in_ready        = 1'b0;
      adder_weight    = FP_ZERO;
      adder_potential = FP_ZERO;
      adder_set       = 1'b0;
      adder_clear     = 1'b0;
      spk_valid       = 1'b0;
      spk_idx         = '0;
      wr_en           = 1'b0;
      wr_idx          = idx_q;
      wr_data         = res_q;

      // A clear request arriving mid-operation is deferred until the FSM is idle again.
      if (clear_all && (state_q != StIdle) && (state_q != StClr)) begin
         clear_pending_d = 1'b1;
      end

      unique case (state_q)
         StCfg: begin
            adder_set = !rst;
            state_d   = StIdle;
         end
         StIdle: begin
            in_ready = !clear_all && !clear_pending_q;
            if (clear_all || clear_pending_q) begin
               clr_cnt_d = '0;
               state_d   = StClr;
            end else if (in_valid) begin
               if (idx_ok) begin
                  idx_d     = in_idx;
                  weight_d  = in_weight;
                  lat_cnt_d = '0;
                  state_d   = StExec;
               end else begin
                  err_idx_d = 1'b1;
               end
            end
         end
         StExec: begin
            adder_weight    = weight_q;
            adder_potential = rd_data;
            lat_cnt_d       = lat_cnt_q + 1'b1;
            if (lat_cnt_q == LAT_LAST) begin
               res_d   = adder_result;
               spk_d   = adder_spike;
               state_d = StWb;
            end
         end
         StWb: begin
            wr_en   = 1'b1;
            state_d = spk_q ? StSpike : StIdle;
         end
         StSpike: begin
            spk_valid = 1'b1;
            spk_idx   = idx_q;
            if (spk_ready) begin
               state_d = StIdle;
               if (spike_count_q != '1) begin
                  spike_count_d = spike_count_q + 1'b1;
               end
            end
         end
         StClr: begin
            adder_clear = 1'b1;
            wr_en       = 1'b1;
            wr_idx      = clr_cnt_q;
            wr_data     = FP_ZERO;
            clr_cnt_d   = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDX_LAST) begin
               clear_pending_d = 1'b0;
               state_d         = StIdle;
            end
         end
         default: begin
            state_d = StCfg;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StCfg;
         idx_q           <= '0;
         weight_q        <= FP_ZERO;
         res_q           <= FP_ZERO;
         spk_q           <= 1'b0;
         lat_cnt_q       <= '0;
         clr_cnt_q       <= '0;
         clear_pending_q <= 1'b0;
         err_idx_q       <= 1'b0;
         spike_count_q   <= '0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         weight_q        <= weight_d;
         res_q           <= res_d;
         spk_q           <= spk_d;
         lat_cnt_q       <= lat_cnt_d;
         clr_cnt_q       <= clr_cnt_d;
         clear_pending_q <= clear_pending_d;
         err_idx_q       <= err_idx_d;
         spike_count_q   <= spike_count_d;
      end
   end

   assign busy        = (state_q != StIdle) || clear_pending_q;
   assign err_idx     = err_idx_q;
   assign spike_count = spike_count_q;

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Directed bench for neuron_update_scheduler: table-driven events plus hand sequences
// for spike back-pressure, deferred and same-cycle clears, bad indices and mid-op reset.
module tb_neuron_update_scheduler;
   import neuron_sched_pkg::*;

   localparam logic [31:0] W_A  = 32'h4247_0A3D; // 49.76
   localparam logic [31:0] W_B  = 32'h425E_D852; // 55.71
   localparam logic [31:0] P_AB = 32'h4216_51EC; // 49.76 + 55.71 - 67.89
   localparam logic [31:0] ONE  = 32'h3F80_0000;
   localparam logic [31:0] TWO  = 32'h4000_0000;
   localparam logic [31:0] HUND = 32'h42C8_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear_all = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_idx = '0;
   logic [31:0] in_weight = '0;
   logic        spk_ready = 1'b0;
   logic        in_ready, adder_set, adder_clear, adder_spike, spk_valid, busy, err_idx;
   logic [31:0] adder_weight, adder_potential, adder_result;
   logic [3:0]  spk_idx;
   logic [15:0] spike_count;

   logic        in_valid12 = 1'b0;
   logic [3:0]  in_idx12 = '0;
   logic        clear_all12 = 1'b0;
   logic        spk_ready12 = 1'b1;
   logic        in_ready12, adder_set12, adder_clear12, adder_spike12, spk_valid12;
   logic        busy12, err_idx12;
   logic [31:0] adder_weight12, adder_potential12, adder_result12;
   logic [3:0]  spk_idx12;
   logic [15:0] spike_count12;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // Stand-in for the external LIF adder: a few known sums, otherwise hold the potential.
   function automatic logic [32:0] adder_model(input logic [31:0] w, input logic [31:0] p);
      if (p == 32'h0) return {(!w[31] && (w > DEFAULT_THRESHOLD)), w};
      if (p == W_A && w == W_B) return {1'b1, P_AB};
      if (p == ONE && w == ONE) return {1'b0, TWO};
      return {1'b0, p};
   endfunction

   assign {adder_spike, adder_result}     = adder_model(adder_weight, adder_potential);
   assign {adder_spike12, adder_result12} = adder_model(adder_weight12, adder_potential12);

   neuron_update_scheduler #(
      .NUM_NEURONS (16), .IDX_W (4), .ADDER_LAT (1), .CNT_W (16)
   ) dut (
      .clk (clk), .rst (rst), .clear_all (clear_all), .in_valid (in_valid),
      .in_ready (in_ready), .in_idx (in_idx), .in_weight (in_weight),
      .adder_weight (adder_weight), .adder_potential (adder_potential),
      .adder_set (adder_set), .adder_clear (adder_clear), .adder_result (adder_result),
      .adder_spike (adder_spike), .spk_valid (spk_valid), .spk_ready (spk_ready),
      .spk_idx (spk_idx), .busy (busy), .err_idx (err_idx), .spike_count (spike_count)
   );

   neuron_update_scheduler #(
      .NUM_NEURONS (12), .IDX_W (4), .ADDER_LAT (1), .CNT_W (16)
   ) dut12 (
      .clk (clk), .rst (rst), .clear_all (clear_all12), .in_valid (in_valid12),
      .in_ready (in_ready12), .in_idx (in_idx12), .in_weight (in_weight),
      .adder_weight (adder_weight12), .adder_potential (adder_potential12),
      .adder_set (adder_set12), .adder_clear (adder_clear12), .adder_result (adder_result12),
      .adder_spike (adder_spike12), .spk_valid (spk_valid12), .spk_ready (spk_ready12),
      .spk_idx (spk_idx12), .busy (busy12), .err_idx (err_idx12), .spike_count (spike_count12)
   );

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] w;
      logic [31:0] exp_pot;
      logic        exp_spk;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (!in_ready && n < 60) begin
         step();
         n++;
      end
      chk({nm, "_ready_wait"}, 32'(in_ready), 32'd1);
   endtask

   // One event through EXEC/WB, releasing any spike immediately.
   task automatic send_event(input string nm, input logic [3:0] idx, input logic [31:0] w,
                             input logic [31:0] exp_pot, input logic exp_spk);
      wait_ready(nm);
      in_valid  = 1'b1;
      in_idx    = idx;
      in_weight = w;
      step();
      in_valid = 1'b0;
      chk({nm, "_exec_w"}, adder_weight, w);
      chk({nm, "_exec_pot"}, adder_potential, exp_pot);
      chk({nm, "_exec_rdy"}, 32'(in_ready), 32'd0);
      step();
      chk({nm, "_wb_rdy"}, 32'(in_ready), 32'd0);
      step();
      chk({nm, "_spk_valid"}, 32'(spk_valid), 32'(exp_spk));
      if (spk_valid) begin
         chk({nm, "_spk_idx"}, 32'(spk_idx), 32'(idx));
         spk_ready = 1'b1;
         step();
         spk_ready = 1'b0;
         chk({nm, "_spk_done"}, 32'(spk_valid), 32'd0);
      end
   endtask

   initial begin
      int n;
      logic [15:0] cnt0;

      vecs[0] = '{idx: 4'd3,  w: W_A,  exp_pot: 32'h0, exp_spk: 1'b0};
      vecs[1] = '{idx: 4'd7,  w: ONE,  exp_pot: 32'h0, exp_spk: 1'b0};
      vecs[2] = '{idx: 4'd7,  w: ONE,  exp_pot: ONE,   exp_spk: 1'b0};
      vecs[3] = '{idx: 4'd0,  w: HUND, exp_pot: 32'h0, exp_spk: 1'b1};
      vecs[4] = '{idx: 4'd15, w: TWO,  exp_pot: 32'h0, exp_spk: 1'b0};
      vecs[5] = '{idx: 4'd0,  w: ONE,  exp_pot: HUND,  exp_spk: 1'b0};
      vecs[6] = '{idx: 4'd15, w: ONE,  exp_pot: TWO,   exp_spk: 1'b0};

      // Reset state and the single-cycle adder_set pulse.
      repeat (3) step();
      chk("rst_adder_set", 32'(adder_set), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_spk_valid", 32'(spk_valid), 32'd0);
      chk("rst_spike_count", 32'(spike_count), 32'd0);
      chk("rst_err_idx", 32'(err_idx), 32'd0);
      rst = 1'b0;
      #1;
      chk("cfg_adder_set", 32'(adder_set), 32'd1);
      chk("cfg_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("idle_adder_set", 32'(adder_set), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 7; i++) begin
         send_event($sformatf("vec%0d", i), vecs[i].idx, vecs[i].w, vecs[i].exp_pot,
                    vecs[i].exp_spk);
      end
      chk("vec_spike_count", 32'(spike_count), 32'd1);

      // Spike held under back-pressure.
      wait_ready("bp");
      in_valid  = 1'b1;
      in_idx    = 4'd3;
      in_weight = W_B;
      step();
      in_valid = 1'b0;
      chk("bp_exec_pot", adder_potential, W_A);
      step();
      step();
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp_spk_valid%0d", c), 32'(spk_valid), 32'd1);
         chk($sformatf("bp_spk_idx%0d", c), 32'(spk_idx), 32'd3);
         chk($sformatf("bp_in_ready%0d", c), 32'(in_ready), 32'd0);
         step();
      end
      cnt0 = spike_count;
      chk("bp_count_held", 32'(cnt0), 32'd1);
      spk_ready = 1'b1;
      step();
      spk_ready = 1'b0;
      chk("bp_spike_count", 32'(spike_count), 32'd2);
      chk("bp_spk_drop", 32'(spk_valid), 32'd0);
      send_event("bp_pot3", 4'd3, ONE, P_AB, 1'b0);

      // clear_all during EXEC: event finishes, then a full clear sweep.
      wait_ready("clr_exec");
      in_valid  = 1'b1;
      in_idx    = 4'd7;
      in_weight = ONE;
      step();
      in_valid  = 1'b0;
      chk("clr_exec_pot", adder_potential, TWO);
      clear_all = 1'b1;
      step();
      clear_all = 1'b0;
      chk("clr_wb_busy", 32'(busy), 32'd1);
      chk("clr_wb_clear", 32'(adder_clear), 32'd0);
      step();
      chk("clr_pend_ready", 32'(in_ready), 32'd0);
      step();
      n = 0;
      for (int c = 0; c < 40 && busy; c++) begin
         if (adder_clear) n++;
         step();
      end
      chk("clr_exec_cycles", 32'(n), 32'd16);
      chk("clr_exec_busy", 32'(busy), 32'd0);
      send_event("clr_pot7", 4'd7, ONE, 32'h0, 1'b0);
      send_event("clr_pot15", 4'd15, ONE, 32'h0, 1'b0);

      // clear_all and in_valid in the same idle cycle.
      wait_ready("clr_same");
      clear_all = 1'b1;
      in_valid  = 1'b1;
      in_idx    = 4'd3;
      in_weight = ONE;
      #1;
      chk("same_in_ready", 32'(in_ready), 32'd0);
      step();
      clear_all = 1'b0;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (adder_weight != 32'h0) break;
         if (adder_clear) n++;
         step();
      end
      in_valid = 1'b0;
      chk("same_clr_cycles", 32'(n), 32'd16);
      chk("same_exec_w", adder_weight, ONE);
      chk("same_exec_pot", adder_potential, 32'h0);
      step();
      step();

      // Out-of-range indices on the 12-neuron instance.
      in_valid12 = 1'b1;
      in_idx12   = 4'd13;
      in_weight  = ONE;
      #1;
      chk("e12_ready", 32'(in_ready12), 32'd1);
      step();
      chk("e12_err", 32'(err_idx12), 32'd1);
      chk("e12_busy", 32'(busy12), 32'd0);
      chk("e12_no_exec", adder_weight12, 32'h0);
      in_idx12 = 4'd12;
      step();
      chk("e12_edge_busy", 32'(busy12), 32'd0);
      in_idx12 = 4'd11;
      step();
      in_valid12 = 1'b0;
      chk("e12_last_w", adder_weight12, ONE);
      chk("e12_last_pot", adder_potential12, 32'h0);
      step();
      step();
      chk("e12_sticky", 32'(err_idx12), 32'd1);
      chk("e16_err_clean", 32'(err_idx), 32'd0);

      // Reset in the middle of EXEC.
      wait_ready("rst_exec");
      in_valid  = 1'b1;
      in_idx    = 4'd3;
      in_weight = ONE;
      step();
      in_valid = 1'b0;
      chk("rx_exec_pot", adder_potential, ONE);
      rst = 1'b1;
      step();
      chk("rx_rst_w", adder_weight, 32'h0);
      chk("rx_rst_set", 32'(adder_set), 32'd0);
      rst = 1'b0;
      #1;
      chk("rx_cfg_set", 32'(adder_set), 32'd1);
      chk("rx_count", 32'(spike_count), 32'd0);
      chk("rx_err12", 32'(err_idx12), 32'd0);
      step();
      chk("rx_idle_ready", 32'(in_ready), 32'd1);
      send_event("rx_pot3", 4'd3, ONE, 32'h0, 1'b0);
      send_event("rx_pot0", 4'd0, ONE, 32'h0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
